chan_err_inj: RTL and testbench
===============================

# chan_err_inj

Synthesizable channel-corruption stage between the rate-1/2 convolutional encoder and the Viterbi decoder. It registers each 2-bit encoder symbol, then either passes it through clean or flips selected bits. Bits are flipped in a fixed burst window, periodically, or pseudo-randomly. It counts delivered words and injected bit errors so benches and on-chip BER runs share one error source.

## Interface
- CNT_W, 32, width of word and bad-bit counters and of win_start_i
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- valid_i  in  1  encoder symbol valid
- d_in  in  2  encoder symbol {g1,g0}
- clr_i  in  1  latch config, zero counters, restart injection
- mode_i  in  2  0 CLEAN, 1 WINDOW, 2 PERIODIC, 3 RANDOM (latched on clr_i)
- err_mask_i  in  2  bits flipped on a corrupted word (latched)
- win_start_i  in  CNT_W  index of first corrupted word, WINDOW mode (latched)
- win_len_i  in  16  burst length in words, WINDOW mode (latched)
- period_i  in  16  PERIODIC spacing in words (latched)
- thresh_i  in  16  RANDOM: corrupt when LFSR < thresh (latched)
- seed_i  in  16  LFSR seed; 0 is replaced by 16'h0001 (latched)
- valid_o  out  1  output symbol valid
- d_out  out  2  possibly corrupted symbol, to decoder
- err_inj_o  out  2  mask actually applied to d_out this word
- word_ct_o  out  CNT_W  valid words accepted since clr_i
- bad_bit_ct_o  out  CNT_W  total bits flipped since clr_i

## Operation
- States: IDLE, WAIT, BURST, DONE, FREE. Reset goes to IDLE with config = CLEAN and mask 0.
- IDLE: pass clean; counters hold at 0; stays until clr_i.
- clr_i has priority in every state:
  - Latches config.
  - Zeroes word_ct, bad_bit_ct, burst and period counters.
  - Loads LFSR from seed.
  - Next state: WAIT for WINDOW with win_len≠0, DONE for WINDOW with win_len=0, otherwise FREE.
  - A word arriving with clr_i is output clean and not counted.
- Word index = word_ct value before increment; first word after clr_i is index 0.
- WAIT: the valid word with index == win_start is corrupted. Go to BURST if win_len>1, else DONE.
- BURST: corrupt every valid word. After win_len words total, go to DONE.
- DONE: clean until clr_i.
- FREE behaviour by mode:
  - CLEAN: pass clean.
  - PERIODIC: period counter advances per valid word. When it equals period-1, corrupt the word and wrap to 0. period=0 never corrupts.
  - RANDOM: compare the current LFSR value to thresh, then advance the LFSR once per valid word. thresh=0 never corrupts.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
- Corrupted word: d_out = d_in ^ mask and err_inj_o = mask. Clean word: err_inj_o = 0.
- word_ct increments per counted valid word. bad_bit_ct adds popcount(applied mask). Both saturate at all-ones.
- Only valid words advance the index, burst, period and LFSR.

## Timing
- Latency: one cycle. valid_o, d_out and err_inj_o are registered from valid_i/d_in.
- d_out holds its last value when valid_o=0; err_inj_o is 0 when valid_o=0.
- Counters update in the same cycle as the corresponding valid_o; counter outputs are registered.
- Reset values: valid_o=0, d_out=0, err_inj_o=0, word_ct_o=0, bad_bit_ct_o=0, state IDLE, LFSR=16'h0001.
- Reset mid-burst: all outputs 0 on the next edge; injection does not resume until clr_i.
- Config inputs are sampled only on clr_i; changes at other times are ignored.

## Structure
- Package chan_pkg:
  - state enum (IDLE, WAIT, BURST, DONE, FREE) and mode enum.
  - LFSR tap constant, default seed 16'h0001, counter saturation helper.
- Sub-module chan_lfsr16: load/advance/value ports, instantiated once.
- Remainder in chan_err_inj: FSM, counters, output register.

## Test plan
- CLEAN, clr_i, then 256 consecutive words -> d_out equals d_in one cycle later; err_inj_o=0; word_ct_o=256; bad_bit_ct_o=0.
- WINDOW start=151, len=4, mask=2'b10, 256 words -> words 151..154 have bit1 inverted, all others clean; bad_bit_ct_o=4; state DONE.
- PERIODIC period=8, mask=2'b11, 64 words -> words 7,15,…,63 fully inverted; bad_bit_ct_o=16.
- RANDOM seed=16'hACE1, thresh=16'h2000, 1000 words -> per-word flips and final bad_bit_ct_o match the golden LFSR model; thresh=0 gives 0 errors.
- WINDOW start=3, len=2, valid_i toggling 1,0,1,0… -> only valid words 3 and 4 corrupted; invalid cycles leave word_ct_o unchanged.
- clr_i with valid_i during BURST -> that word clean and uncounted; counters 0; state WAIT. rst low mid-burst -> all outputs 0 on next edge; state IDLE.

Source files
------------

// File: rtl/chan_pkg.sv
// chan_pkg: shared types, LFSR constants and saturating-add helper for the channel error injector.
package chan_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_BURST, ST_DONE, ST_FREE} state_t;
    typedef enum logic [1:0] {MD_CLEAN, MD_WINDOW, MD_PERIODIC, MD_RANDOM} mode_t;
    // x^16+x^14+x^13+x^11+1 as bit positions 15,13,12,10 of a left-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'h0001;
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] lim, sum;
        lim = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
        sum = a + b;
        return (sum < a || sum > lim) ? lim : sum;
    endfunction
endpackage

// File: rtl/chan_lfsr16.sv
// chan_lfsr16: 16-bit Fibonacci LFSR with seed load (zero seed forced to default) and advance.
module chan_lfsr16
    import chan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_seed,
    input  logic        i_adv,
    output logic [15:0] o_value
);
    logic [15:0] r_q;
    always_ff @(posedge clk) begin
        if (!rst)
            r_q <= LFSR_SEED;
        else if (i_load)
            r_q <= (i_seed == 16'd0) ? LFSR_SEED : i_seed;
        else if (i_adv)
            r_q <= {r_q[14:0], ^(r_q & LFSR_TAPS)};
    end
    assign o_value = r_q;
endmodule

// File: rtl/chan_err_inj.sv
// chan_err_inj: registers encoder symbols and flips masked bits in window, periodic or random patterns.
module chan_err_inj
    import chan_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [1:0]       d_in,
    input  logic             clr_i,
    input  logic [1:0]       mode_i,
    input  logic [1:0]       err_mask_i,
    input  logic [CNT_W-1:0] win_start_i,
    input  logic [15:0]      win_len_i,
    input  logic [15:0]      period_i,
    input  logic [15:0]      thresh_i,
    input  logic [15:0]      seed_i,
    output logic             valid_o,
    output logic [1:0]       d_out,
    output logic [1:0]       err_inj_o,
    output logic [CNT_W-1:0] word_ct_o,
    output logic [CNT_W-1:0] bad_bit_ct_o
);
    state_t           r_state;
    mode_t            r_mode;
    logic [1:0]       r_mask;
    logic [CNT_W-1:0] r_win_start, r_word_ct, r_bad_ct;
    logic [15:0]      r_win_len, r_period, r_thresh, r_burst_ct, r_per_ct;
    logic [15:0]      w_lfsr;
    logic             w_cnt, w_hit;
    logic [1:0]       w_app;

    chan_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (clr_i),
        .i_seed  (seed_i),
        .i_adv   (w_cnt && r_state == ST_FREE && r_mode == MD_RANDOM),
        .o_value (w_lfsr)
    );

    // A word arriving with clr_i is neither counted nor corrupted
    always_comb begin
        w_cnt = valid_i && !clr_i && r_state != ST_IDLE;
        w_hit = w_cnt && ((r_state == ST_WAIT && r_word_ct == r_win_start) ||
                          r_state == ST_BURST ||
                          (r_state == ST_FREE &&
                           ((r_mode == MD_PERIODIC && r_period != 16'd0 &&
                             r_per_ct == r_period - 16'd1) ||
                            (r_mode == MD_RANDOM && w_lfsr < r_thresh))));
        w_app = w_hit ? r_mask : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MD_CLEAN;
            r_mask      <= 2'b00;
            r_win_start <= '0;
            r_win_len   <= '0;
            r_period    <= '0;
            r_thresh    <= '0;
            r_burst_ct  <= '0;
            r_per_ct    <= '0;
            r_word_ct   <= '0;
            r_bad_ct    <= '0;
            valid_o     <= 1'b0;
            d_out       <= 2'b00;
            err_inj_o   <= 2'b00;
        end else begin
            valid_o   <= valid_i;
            err_inj_o <= valid_i ? w_app : 2'b00;
            if (valid_i)
                d_out <= d_in ^ w_app;
            if (clr_i) begin
                r_mode      <= mode_t'(mode_i);
                r_mask      <= err_mask_i;
                r_win_start <= win_start_i;
                r_win_len   <= win_len_i;
                r_period    <= period_i;
                r_thresh    <= thresh_i;
                r_burst_ct  <= '0;
                r_per_ct    <= '0;
                r_word_ct   <= '0;
                r_bad_ct    <= '0;
                r_state     <= (mode_t'(mode_i) != MD_WINDOW) ? ST_FREE :
                               (win_len_i != 16'd0) ? ST_WAIT : ST_DONE;
            end else if (w_cnt) begin
                r_word_ct <= CNT_W'(sat_add(64'(r_word_ct), 64'd1, CNT_W));
                r_bad_ct  <= CNT_W'(sat_add(64'(r_bad_ct), 64'(w_app[0]) + 64'(w_app[1]), CNT_W));
                if (r_state == ST_WAIT && w_hit) begin
                    r_burst_ct <= 16'd1;
                    r_state    <= (r_win_len > 16'd1) ? ST_BURST : ST_DONE;
                end
                if (r_state == ST_BURST) begin
                    r_burst_ct <= r_burst_ct + 16'd1;
                    if (r_burst_ct + 16'd1 == r_win_len)
                        r_state <= ST_DONE;
                end
                if (r_state == ST_FREE && r_mode == MD_PERIODIC)
                    r_per_ct <= w_hit ? 16'd0 : r_per_ct + 16'd1;
            end
        end
    end

    assign word_ct_o    = r_word_ct;
    assign bad_bit_ct_o = r_bad_ct;
endmodule

// File: tb/tb_chan_err_inj.sv
// tb_chan_err_inj: directed sequence with random symbols, checked against a word-index based model.
module tb_chan_err_inj;
    import chan_pkg::*;
    logic        clk = 0, rst = 0, valid_i = 0, clr_i = 0;
    logic [1:0]  d_in = 0, mode_i = 0, err_mask_i = 0;
    logic [31:0] win_start_i = 0;
    logic [15:0] win_len_i = 0, period_i = 0, thresh_i = 0, seed_i = 0;
    logic        valid_o;
    logic [1:0]  d_out, err_inj_o;
    logic [31:0] word_ct_o, bad_bit_ct_o;

    int          checks = 0, errors = 0;
    int          tmode, tper;
    logic [1:0]  tmask, prev_d;
    longint      tstart, tlen, idx, ebad;
    logic [15:0] tthr, ml;

    chan_err_inj #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .d_in(d_in), .clr_i(clr_i),
        .mode_i(mode_i), .err_mask_i(err_mask_i), .win_start_i(win_start_i),
        .win_len_i(win_len_i), .period_i(period_i), .thresh_i(thresh_i), .seed_i(seed_i),
        .valid_o(valid_o), .d_out(d_out), .err_inj_o(err_inj_o),
        .word_ct_o(word_ct_o), .bad_bit_ct_o(bad_bit_ct_o)
    );

    always #5 clk = ~clk;

    // Polynomial x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic word(input bit v);
        logic [1:0] d, m;
        bit hit;
        d = 2'($urandom);
        hit = 0;
        if (v) begin
            case (tmode)
                1: hit = (idx >= tstart) && (idx < tstart + tlen);
                2: hit = (tper != 0) && ((idx + 1) % tper == 0);
                3: hit = (ml < tthr);
                default: hit = 0;
            endcase
        end
        m = hit ? tmask : 2'b00;
        valid_i = v;
        d_in = d;
        @(posedge clk); #1;
        if (v) begin
            if (tmode >= 0) idx++;
            ebad += longint'(m[0]) + longint'(m[1]);
            if (tmode == 3) ml = lfsr_next(ml);
            prev_d = d ^ m;
        end
        chk("valid_o", 32'(valid_o), 32'(v));
        chk("err_inj_o", 32'(err_inj_o), 32'(m));
        chk("d_out", 32'(d_out), 32'(prev_d));
        chk("word_ct", word_ct_o, 32'(idx));
        chk("bad_ct", bad_bit_ct_o, 32'(ebad));
    endtask

    task automatic do_clr(input int md, input logic [1:0] mk, input longint st, input int ln,
                          input int pr, input logic [15:0] th, input logic [15:0] sd, input bit v);
        logic [1:0] d;
        d = 2'($urandom);
        mode_i = 2'(md); err_mask_i = mk; win_start_i = 32'(st); win_len_i = 16'(ln);
        period_i = 16'(pr); thresh_i = th; seed_i = sd;
        clr_i = 1; valid_i = v; d_in = d;
        @(posedge clk); #1;
        clr_i = 0; valid_i = 0;
        tmode = md; tmask = mk; tstart = st; tlen = ln; tper = pr; tthr = th;
        ml = (sd == 16'd0) ? 16'h0001 : sd;
        idx = 0; ebad = 0;
        if (v) prev_d = d;
        chk("clr_valid_o", 32'(valid_o), 32'(v));
        chk("clr_err_inj", 32'(err_inj_o), 32'd0);
        chk("clr_d_out", 32'(d_out), 32'(prev_d));
        chk("clr_word_ct", word_ct_o, 32'd0);
        chk("clr_bad_ct", bad_bit_ct_o, 32'd0);
        // config changes outside clr_i must be ignored
        mode_i = 2'($urandom); err_mask_i = 2'($urandom); win_start_i = $urandom;
        win_len_i = 16'($urandom); period_i = 16'($urandom); thresh_i = 16'($urandom);
        seed_i = 16'($urandom);
    endtask

    initial begin
        tmode = -1; tmask = 0; tstart = 0; tlen = 0; tper = 0; tthr = 0; ml = 1;
        idx = 0; ebad = 0; prev_d = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_d_out", 32'(d_out), 32'd0);
        chk("rst_err_inj", 32'(err_inj_o), 32'd0);
        chk("rst_word_ct", word_ct_o, 32'd0);
        chk("rst_bad_ct", bad_bit_ct_o, 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        rst = 1;
        // IDLE: clean pass-through, counters held (tmode -1 keeps idx at 0)
        for (int i = 0; i < 4; i++) begin
            valid_i = 1; d_in = 2'(i);
            @(posedge clk); #1;
            chk("idle_d_out", 32'(d_out), 32'(i));
            chk("idle_err_inj", 32'(err_inj_o), 32'd0);
            chk("idle_word_ct", word_ct_o, 32'd0);
            prev_d = 2'(i);
        end
        valid_i = 0;
        do_clr(0, 2'b11, 0, 0, 0, 16'hFFFF, 16'h1234, 0);
        repeat (256) word(1);
        chk("clean_word_ct", word_ct_o, 32'd256);
        do_clr(1, 2'b10, 151, 4, 0, 0, 0, 0);
        repeat (256) word(1);
        chk("win_bad_ct", bad_bit_ct_o, 32'd4);
        chk("win_state", 32'(dut.r_state), 32'(ST_DONE));
        do_clr(2, 2'b11, 0, 0, 8, 0, 0, 0);
        repeat (64) word(1);
        chk("per_bad_ct", bad_bit_ct_o, 32'd16);
        do_clr(3, 2'b11, 0, 0, 0, 16'h2000, 16'hACE1, 0);
        repeat (1000) word(1);
        do_clr(3, 2'b01, 0, 0, 0, 16'h0000, 16'hACE1, 0);
        repeat (200) word(1);
        chk("rnd_thr0_bad", bad_bit_ct_o, 32'd0);
        do_clr(3, 2'b10, 0, 0, 0, 16'h8000, 16'h0000, 0);
        repeat (200) word(1);
        do_clr(2, 2'b01, 0, 0, 0, 0, 0, 0);
        repeat (40) word(1);
        do_clr(1, 2'b11, 0, 0, 0, 0, 0, 0);
        chk("len0_state", 32'(dut.r_state), 32'(ST_DONE));
        repeat (5) word(1);
        do_clr(1, 2'b01, 3, 2, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) word(i % 2 == 0);
        do_clr(1, 2'b01, 2, 5, 0, 0, 0, 0);
        repeat (4) word(1);
        chk("burst_state", 32'(dut.r_state), 32'(ST_BURST));
        do_clr(1, 2'b01, 2, 5, 0, 0, 0, 1);
        chk("reclr_state", 32'(dut.r_state), 32'(ST_WAIT));
        repeat (10) word(1);
        do_clr(1, 2'b11, 1, 8, 0, 0, 0, 0);
        repeat (3) word(1);
        rst = 0; valid_i = 1; d_in = 2'b11;
        @(posedge clk); #1;
        chk("mid_rst_valid_o", 32'(valid_o), 32'd0);
        chk("mid_rst_d_out", 32'(d_out), 32'd0);
        chk("mid_rst_err_inj", 32'(err_inj_o), 32'd0);
        chk("mid_rst_word_ct", word_ct_o, 32'd0);
        chk("mid_rst_bad_ct", bad_bit_ct_o, 32'd0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        rst = 1;
        tmode = -1; idx = 0; ebad = 0; prev_d = 0;
        repeat (6) word(1);
        chk("post_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
